// File: rtl/word_serializer.sv
// word_serializer: latches a WORD_BYTES-wide word on a one-cycle ready_i request and streams it
// one character at a time into the avr_interface serial TX user port.
//
// Parameters:
//   WORD_BYTES - bytes in word_i (1..128)
//   HEX_MODE   - 0: one raw byte per word byte; 1: two uppercase ASCII hex chars, upper nibble first
//   MSB_FIRST  - 1: byte WORD_BYTES-1 goes out first; 0: byte 0 goes out first
//   APPEND_NL  - 1: append 0x0D 0x0A after the word (hex mode only)
//
// Ports:
//   clk_i      - system clock
//   rst_n_i    - asynchronous active-low reset
//   word_i     - word to send, sampled only when a request is accepted
//   ready_i    - one-cycle request, word_i valid
//   tx_data_o  - character to avr_interface tx_data
//   tx_new_o   - one-cycle strobe to avr_interface new_tx_data
//   tx_busy_i  - avr_interface tx_busy
//   busy_o     - high from accept until done_o
//   done_o     - one-cycle pulse after the last character
//   overrun_o  - sticky: a request arrived while busy (cleared only by reset)
module word_serializer #(
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned HEX_MODE   = 0,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned APPEND_NL  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [8*WORD_BYTES-1:0] word_i,
  input  logic                    ready_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_new_o,
  input  logic                    tx_busy_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);

  localparam bit          HexEn     = (HEX_MODE != 0);
  localparam bit          MsbEn     = (MSB_FIRST != 0);
  localparam bit          NlEn      = HexEn && (APPEND_NL != 0);
  localparam int unsigned DataChars = WORD_BYTES * (HexEn ? 2 : 1);
  localparam int unsigned Total     = DataChars + (NlEn ? 2 : 0);
  localparam int unsigned CntW      = $clog2(Total + 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                  state_q, state_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_new_q, tx_new_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;

  // Character selection for the current counter value
  logic [31:0] cnt_ext;
  logic [31:0] idx;
  logic [31:0] pos;
  logic [7:0]  cur_byte;
  logic [3:0]  nib;
  logic [7:0]  hex_char;
  logic [7:0]  cur_char;

  always_comb begin
    cnt_ext = 32'(cnt_q);
    idx     = HexEn ? (cnt_ext >> 1) : cnt_ext;
    // Terminator positions have no byte behind them; keep the mux index in range
    if (idx >= WORD_BYTES) begin
      idx = '0;
    end
    pos = MsbEn ? (WORD_BYTES - 1 - idx) : idx;

    cur_byte = '0;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (pos == b) begin
        cur_byte = word_q[8*b +: 8];
      end
    end

    nib      = cnt_q[0] ? cur_byte[3:0] : cur_byte[7:4];
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

    if (NlEn && (cnt_ext >= DataChars)) begin
      cur_char = (cnt_ext == DataChars) ? 8'h0D : 8'h0A;
    end else if (HexEn) begin
      cur_char = hex_char;
    end else begin
      cur_char = cur_byte;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_new_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      StIdle: begin
        if (ready_i) begin
          // The done cycle still counts as busy: a request there is an overrun
          if (done_q) begin
            overrun_d = 1'b1;
          end else begin
            word_d  = word_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (ready_i) begin
          overrun_d = 1'b1;
        end
        if (!tx_busy_i) begin
          tx_data_d = cur_char;
          tx_new_d  = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          state_d   = StGap;
        end
      end
      StGap: begin
        // avr_interface raises tx_busy one cycle after the strobe, so tx_busy_i is ignored here
        if (ready_i) begin
          overrun_d = 1'b1;
        end
        if (cnt_q == CntW'(Total)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StSend;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      word_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_new_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_new_q  <= tx_new_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_new_o  = tx_new_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer. Four instances cover raw/MSB-first, hex+CRLF/MSB-first,
// hex+CRLF/LSB-first and a 128-byte hex word. Only the instance selected by `act` is exercised
// at a time; a negedge monitor captures its strobes and models avr_interface tx_busy.
module tb_word_serializer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] word;
  logic          ready   [4];
  logic          tx_busy [4];
  logic [7:0]    tx_data [4];
  logic          tx_new  [4];
  logic          busy    [4];
  logic          done    [4];
  logic          overrun [4];

  always #10 clk = ~clk;

  word_serializer #(.WORD_BYTES(8), .HEX_MODE(0), .MSB_FIRST(1), .APPEND_NL(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .word_i(word[63:0]), .ready_i(ready[0]),
    .tx_data_o(tx_data[0]), .tx_new_o(tx_new[0]), .tx_busy_i(tx_busy[0]),
    .busy_o(busy[0]), .done_o(done[0]), .overrun_o(overrun[0])
  );
  word_serializer #(.WORD_BYTES(8), .HEX_MODE(1), .MSB_FIRST(1), .APPEND_NL(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .word_i(word[63:0]), .ready_i(ready[1]),
    .tx_data_o(tx_data[1]), .tx_new_o(tx_new[1]), .tx_busy_i(tx_busy[1]),
    .busy_o(busy[1]), .done_o(done[1]), .overrun_o(overrun[1])
  );
  word_serializer #(.WORD_BYTES(8), .HEX_MODE(1), .MSB_FIRST(0), .APPEND_NL(1)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .word_i(word[63:0]), .ready_i(ready[2]),
    .tx_data_o(tx_data[2]), .tx_new_o(tx_new[2]), .tx_busy_i(tx_busy[2]),
    .busy_o(busy[2]), .done_o(done[2]), .overrun_o(overrun[2])
  );
  word_serializer #(.WORD_BYTES(128), .HEX_MODE(1), .MSB_FIRST(1), .APPEND_NL(0)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .word_i(word), .ready_i(ready[3]),
    .tx_data_o(tx_data[3]), .tx_new_o(tx_new[3]), .tx_busy_i(tx_busy[3]),
    .busy_o(busy[3]), .done_o(done[3]), .overrun_o(overrun[3])
  );

  int         vectors = 0;
  int         errors  = 0;
  int         act     = 0;
  int         blen    = 0;
  int         bcnt    = 0;
  int         cyc     = 0;
  logic [7:0] got   [$];
  int         stb_cyc [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_data [4];
  string      hexdig = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    vectors++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, want);
    end
  endtask

  // Monitor and tx_busy model: busy rises right after a strobe and stays up blen cycles
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bcnt = 0;
      for (int i = 0; i < 4; i++) last_data[i] = 8'h00;
    end else begin
      if (tx_new[act]) begin
        check("no strobe while tx_busy", {31'd0, tx_busy[act]}, 32'd0);
        check("busy_o during strobe", {31'd0, busy[act]}, 32'd1);
        if (stb_cyc.size() > 0) begin
          check("strobe spacing >= 2", {31'd0, (cyc - stb_cyc[stb_cyc.size()-1]) >= 2}, 32'd1);
        end
        got.push_back(tx_data[act]);
        stb_cyc.push_back(cyc);
        last_data[act] = tx_data[act];
      end else begin
        check("tx_data stable between strobes", {24'd0, tx_data[act]}, {24'd0, last_data[act]});
      end
      if (bcnt > 0) bcnt--;
      if (tx_new[act] && blen > 0) bcnt = blen;
    end
    for (int i = 0; i < 4; i++) tx_busy[i] = (i == act) && (bcnt > 0);
  end

  // Reference character stream, built straight from the word and the instance configuration
  task automatic build_exp(input int d, input logic [1023:0] w);
    int wb, hx, msb, nl, k;
    logic [7:0] b;
    case (d)
      0:       begin wb = 8;   hx = 0; msb = 1; nl = 0; end
      1:       begin wb = 8;   hx = 1; msb = 1; nl = 1; end
      2:       begin wb = 8;   hx = 1; msb = 0; nl = 1; end
      default: begin wb = 128; hx = 1; msb = 1; nl = 0; end
    endcase
    exp_q.delete();
    for (int c = 0; c < wb; c++) begin
      k = msb ? (wb - 1 - c) : c;
      b = 8'(w >> (8 * k));
      if (hx != 0) begin
        exp_q.push_back(hexdig[b[7:4]]);
        exp_q.push_back(hexdig[b[3:0]]);
      end else begin
        exp_q.push_back(b);
      end
    end
    if (hx != 0 && nl != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Pulse ready for one cycle; returns at the negedge where the first strobe is due
  task automatic start_word(input int d, input logic [1023:0] w, input int bl);
    @(negedge clk);
    act = d;
    blen = bl;
    got.delete();
    stb_cyc.delete();
    word = w;
    ready[d] = 1'b1;
    @(negedge clk);
    ready[d] = 1'b0;
    check("busy_o after accept", {31'd0, busy[d]}, 32'd1);
    @(negedge clk);
    check("first strobe latency", {31'd0, tx_new[d]}, 32'd1);
  endtask

  // Wait for done_o; with settle=1 also check the pulse width and idle out
  task automatic wait_done(input int d, input int budget, input bit settle);
    int t;
    logic prev;
    t = 0;
    prev = 1'b0;
    while (!done[d] && t < budget) begin
      prev = tx_new[d];
      @(negedge clk);
      t++;
    end
    check("done within budget", {31'd0, done[d]}, 32'd1);
    check("done one cycle after last strobe", {31'd0, prev}, 32'd1);
    check("busy_o low with done", {31'd0, busy[d]}, 32'd0);
    if (settle) begin
      @(negedge clk);
      check("done one cycle wide", {31'd0, done[d]}, 32'd0);
      repeat (14) @(negedge clk);
    end
  endtask

  task automatic wait_chars(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reached character count", {31'd0, got.size() >= n}, 32'd1);
  endtask

  task automatic compare_run(input string tag, input int bl);
    int n;
    check({tag, " char count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s char %0d", tag, j), {24'd0, got[j]}, {24'd0, exp_q[j]});
    end
    if (bl == 0) begin
      for (int j = 1; j < got.size(); j++) begin
        check($sformatf("%s spacing %0d", tag, j), stb_cyc[j] - stb_cyc[j-1], 32'd2);
      end
    end
  endtask

  typedef struct {
    int           dut;
    logic [63:0]  w;
    int           bl;
    int           len;
    logic [143:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] w;
    logic [7:0]    e;
    int            n;

    rst_n = 1'b0;
    word  = '0;
    for (int i = 0; i < 4; i++) ready[i] = 1'b0;

    tbl[0] = '{0, 64'h0123456789ABCDEF, 0,  8, 144'h0123456789ABCDEF};
    tbl[1] = '{1, 64'h0123456789ABCDEF, 0, 18, "0123456789ABCDEF\r\n"};
    tbl[2] = '{2, 64'h0123456789ABCDEF, 0, 18, "EFCDAB8967452301\r\n"};
    tbl[3] = '{0, 64'h0123456789ABCDEF, 10, 8, 144'h0123456789ABCDEF};
    tbl[4] = '{2, 64'hFEDCBA9876543210, 10, 18, "1032547698BADCFE\r\n"};
    tbl[5] = '{0, 64'h00FF00FFA5A55A5A, 0,  8, 144'h00FF00FFA5A55A5A};

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx_data dut%0d", i), {24'd0, tx_data[i]}, 32'd0);
      check($sformatf("reset tx_new dut%0d", i), {31'd0, tx_new[i]}, 32'd0);
      check($sformatf("reset busy dut%0d", i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("reset done dut%0d", i), {31'd0, done[i]}, 32'd0);
      check($sformatf("reset overrun dut%0d", i), {31'd0, overrun[i]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors with independently written expected strings
    for (int v = 0; v < 6; v++) begin
      start_word(tbl[v].dut, {960'd0, tbl[v].w}, tbl[v].bl);
      wait_done(tbl[v].dut, 3000, 1'b1);
      check($sformatf("tbl%0d count", v), got.size(), tbl[v].len);
      for (int j = 0; j < tbl[v].len && j < got.size(); j++) begin
        e = 8'(tbl[v].exp >> (8 * (tbl[v].len - 1 - j)));
        check($sformatf("tbl%0d char %0d", v, j), {24'd0, got[j]}, {24'd0, e});
      end
      check($sformatf("tbl%0d overrun", v), {31'd0, overrun[tbl[v].dut]}, 32'd0);
    end

    // ready_i at the 3rd character: original word completes, overrun sticks
    w = {960'd0, 64'h0123456789ABCDEF};
    build_exp(1, w);
    start_word(1, w, 0);
    wait_chars(3);
    @(negedge clk);
    word = {960'd0, 64'hDEADBEEFCAFEF00D};
    ready[1] = 1'b1;
    @(negedge clk);
    ready[1] = 1'b0;
    check("overrun set on busy request", {31'd0, overrun[1]}, 32'd1);
    wait_done(1, 3000, 1'b0);
    compare_run("overrun word", 0);
    // ready_i in the cycle after done_o: accepted back-to-back
    w = {960'd0, 64'h5A5AA5A5_13579BDF};
    build_exp(1, w);
    @(negedge clk);
    got.delete();
    stb_cyc.delete();
    word = w;
    ready[1] = 1'b1;
    @(negedge clk);
    ready[1] = 1'b0;
    check("back-to-back accepted", {31'd0, busy[1]}, 32'd1);
    wait_done(1, 3000, 1'b1);
    compare_run("back-to-back", 0);
    check("overrun still set", {31'd0, overrun[1]}, 32'd1);

    // ready_i during the done cycle is an overrun and is not accepted
    w = {960'd0, 64'h0011223344556677};
    build_exp(2, w);
    start_word(2, w, 0);
    wait_done(2, 3000, 1'b0);
    ready[2] = 1'b1;
    @(negedge clk);
    ready[2] = 1'b0;
    check("done-cycle request overrun", {31'd0, overrun[2]}, 32'd1);
    check("done-cycle request ignored", {31'd0, busy[2]}, 32'd0);
    repeat (12) @(negedge clk);
    compare_run("done-cycle word", 0);

    // ready_i held high for three cycles: one transfer, overrun set
    w = {960'd0, 64'h8877665544332211};
    build_exp(0, w);
    @(negedge clk);
    act = 0;
    blen = 0;
    got.delete();
    stb_cyc.delete();
    word = w;
    ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    ready[0] = 1'b0;
    wait_done(0, 3000, 1'b1);
    compare_run("held ready", 0);
    check("held ready overrun", {31'd0, overrun[0]}, 32'd1);

    // Asynchronous reset at the 5th character
    w = {960'd0, 64'hA1B2C3D4E5F60718};
    start_word(0, w, 0);
    wait_chars(5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset tx_data", {24'd0, tx_data[0]}, 32'd0);
    check("async reset tx_new", {31'd0, tx_new[0]}, 32'd0);
    check("async reset busy", {31'd0, busy[0]}, 32'd0);
    check("async reset done", {31'd0, done[0]}, 32'd0);
    check("async reset overrun dut0", {31'd0, overrun[0]}, 32'd0);
    check("async reset overrun dut1", {31'd0, overrun[1]}, 32'd0);
    check("async reset overrun dut2", {31'd0, overrun[2]}, 32'd0);
    n = got.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no strobes after reset", got.size(), n);
    w = {960'd0, 64'h0F1E2D3C4B5A6978};
    build_exp(0, w);
    start_word(0, w, 0);
    wait_done(0, 3000, 1'b1);
    compare_run("after reset", 0);

    // Randomized words and tx_busy lengths against the reference model
    for (int r = 0; r < 12; r++) begin
      int d, bl;
      d  = int'($urandom_range(0, 2));
      bl = int'($urandom_range(0, 12));
      w  = {960'd0, $urandom, $urandom};
      build_exp(d, w);
      start_word(d, w, bl);
      wait_done(d, 3000, 1'b1);
      compare_run($sformatf("rand%0d", r), bl);
    end

    // 128-byte hex word with a counting pattern
    for (int i = 0; i < 128; i++) w[8*i +: 8] = 8'(i);
    build_exp(3, w);
    start_word(3, w, 0);
    wait_done(3, 3000, 1'b1);
    compare_run("wide", 0);
    check("wide total 256", got.size(), 32'd256);
    if (got.size() == 256) begin
      check("wide last pair hi", {24'd0, got[254]}, 32'h30);
      check("wide last pair lo", {24'd0, got[255]}, 32'h30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
